// File: rtl/debugger_tx_if.sv
// debugger_tx_if: frame-source and UART TX FIFO handshake for the debug transmitter
interface debugger_tx_if #(parameter int NUM_BYTES = 220);
    localparam int DATA_W = 8 * NUM_BYTES;
    logic              sendSignal;
    logic [DATA_W-1:0] sendData;
    logic              tx_full;
    logic              wr_uart;
    logic [7:0]        w_data;
    logic              busy;
    logic              done;
    modport master(output sendSignal, sendData, tx_full, input wr_uart, w_data, busy, done);
    modport slave(input sendSignal, sendData, tx_full, output wr_uart, w_data, busy, done);
endinterface

// File: rtl/debugger_tx.sv
// debugger_tx: captures a NUM_BYTES debug frame and writes it LSB-first into the UART TX FIFO,
// one byte per two clocks at most, pulsing done after the last write.
module debugger_tx #(
    parameter int NUM_BYTES = 220,
    parameter int DATA_W    = 8 * NUM_BYTES
) (
    input  logic         clock,
    input  logic         reset,
    debugger_tx_if.slave bus
);
    localparam int IW = $clog2(NUM_BYTES + 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_BYTES);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t            state, state_n;
    logic [DATA_W-1:0] buffer, buffer_n;
    logic [IW-1:0]     idx, idx_n;
    logic              wr_n, busy_n, done_n;
    logic [7:0]        w_n;
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            buffer      <= '0;
            idx         <= '0;
            bus.wr_uart <= 1'b0;
            bus.w_data  <= 8'h00;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            state       <= state_n;
            buffer      <= buffer_n;
            idx         <= idx_n;
            bus.wr_uart <= wr_n;
            bus.w_data  <= w_n;
            bus.busy    <= busy_n;
            bus.done    <= done_n;
        end
    end
    // The end-of-frame test sits in the SEND slot after the final gap, so done lands
    // 2*NUM_BYTES+1 edges after acceptance and busy covers that whole span.
    always_comb begin
        state_n  = state;
        buffer_n = buffer;
        idx_n    = idx;
        wr_n     = 1'b0;
        w_n      = bus.w_data;
        busy_n   = bus.busy;
        done_n   = 1'b0;
        case (state)
            IDLE: if (bus.sendSignal) begin
                buffer_n = bus.sendData;
                idx_n    = '0;
                busy_n   = 1'b1;
                state_n  = SEND;
            end
            SEND: if (idx == LAST) begin
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
            end else if (!bus.tx_full) begin
                wr_n     = 1'b1;
                w_n      = buffer[7:0];
                buffer_n = buffer >> 8;
                idx_n    = idx + 1'b1;
                state_n  = GAP;
            end
            GAP:     state_n = SEND;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_debugger_tx.sv
// tb_debugger_tx: randomized frames on a 220-byte and a 4-byte instance, checked cycle by cycle
// against a schedule model of write slots, FIFO stalls and the done/busy window.
module tb_debugger_tx;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic sel   = 1'b0;
    int   checks = 0;
    int   errors = 0;
    debugger_tx_if #(.NUM_BYTES(220)) bb();
    debugger_tx_if #(.NUM_BYTES(4))   sb();
    debugger_tx #(.NUM_BYTES(220)) u_big  (.clock(clock), .reset(reset), .bus(bb));
    debugger_tx #(.NUM_BYTES(4))   u_small(.clock(clock), .reset(reset), .bus(sb));
    logic       m_wr, m_busy, m_done;
    logic [7:0] m_data;
    assign m_wr   = sel ? bb.wr_uart : sb.wr_uart;
    assign m_busy = sel ? bb.busy    : sb.busy;
    assign m_done = sel ? bb.done    : sb.done;
    assign m_data = sel ? bb.w_data  : sb.w_data;
    always #5 clock = ~clock;

    function automatic logic [1759:0] rand_frame();
        logic [1759:0] v;
        for (int w = 0; w < 55; w++) v[32*w +: 32] = $urandom();
        return v;
    endfunction

    task automatic drive(input logic go, input logic [1759:0] data, input logic full);
        bb.sendSignal = sel & go;
        sb.sendSignal = !sel & go;
        bb.sendData   = data;
        sb.sendData   = data[31:0];
        bb.tx_full    = sel & full;
        sb.tx_full    = !sel & full;
    endtask

    // Caller sits at a falling edge; returns at the falling edge where done is seen.
    task automatic run_frame(input string name, input logic [1759:0] data,
                             input int stall_at, input int stall_len, input int intr_at);
        int n, t, d, k;
        int wt[220];
        logic exp_wr;
        n = sel ? 220 : 4;
        t = 2;
        for (int b = 0; b < n; b++) begin
            while (t - 1 >= stall_at && t - 1 < stall_at + stall_len) t++;
            wt[b] = t;
            t += 2;
        end
        d = t;
        k = 0;
        drive(1'b1, data, 1'b0);
        for (int j = 1; j <= d; j++) begin
            @(negedge clock);
            exp_wr = (k < n) && (j == wt[k]);
            checks++;
            if (m_wr !== exp_wr) begin
                errors++;
                $display("FAIL %s wr j=%0d got %b want %b", name, j, m_wr, exp_wr);
            end
            if (exp_wr) begin
                checks++;
                if (m_data !== data[8*k +: 8]) begin
                    errors++;
                    $display("FAIL %s byte%0d got %h want %h", name, k, m_data, data[8*k +: 8]);
                end
                k++;
            end
            checks++;
            if (m_done !== (j == d)) begin
                errors++;
                $display("FAIL %s done j=%0d got %b want %b", name, j, m_done, (j == d));
            end
            checks++;
            if (m_busy !== (j < d)) begin
                errors++;
                $display("FAIL %s busy j=%0d got %b want %b", name, j, m_busy, (j < d));
            end
            if (j < d)
                drive(j == intr_at && j <= d - 2, rand_frame(),
                      j >= stall_at && j < stall_at + stall_len);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sel   = 1'b0;
        bb.sendSignal = 1'b1; sb.sendSignal = 1'b1;
        bb.sendData = rand_frame(); sb.sendData = 32'h12345678;
        bb.tx_full = 1'b0; sb.tx_full = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            checks++;
            if ({bb.wr_uart, bb.busy, bb.done, bb.w_data} !== 11'd0) begin
                errors++;
                $display("FAIL reset_big got %b %b %b %h want 0 0 0 00", bb.wr_uart, bb.busy, bb.done, bb.w_data);
            end
            checks++;
            if ({sb.wr_uart, sb.busy, sb.done, sb.w_data} !== 11'd0) begin
                errors++;
                $display("FAIL reset_small got %b %b %b %h want 0 0 0 00", sb.wr_uart, sb.busy, sb.done, sb.w_data);
            end
        end
        drive(1'b0, '0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        sel = 1'b1;
        run_frame("basic", {220{8'h43}}, 1000, 0, 0);
        run_frame("big_random", rand_frame(), 37, 5, 100);
        drive(1'b0, '0, 1'b0);
        @(negedge clock);
        sel = 1'b0;
    endtask

    task automatic test_byte_order();
        logic [1759:0] v;
        v = '0;
        v[31:0] = 32'hDDCCBBAA;
        run_frame("byte_order", v, 1000, 0, 0);
        drive(1'b0, '0, 1'b0);
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        run_frame("backpressure", rand_frame(), 5, 10, 0);
        drive(1'b0, '0, 1'b0);
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        run_frame("busy_request", rand_frame(), 1000, 0, 3);
        run_frame("back_to_back", rand_frame(), 1000, 0, 5);
        drive(1'b0, '0, 1'b0);
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        logic [1759:0] data;
        data = rand_frame();
        drive(1'b1, data, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clock);
            drive(1'b0, rand_frame(), 1'b0);
        end
        checks++;
        if (m_wr !== 1'b1 || m_data !== data[15:8]) begin
            errors++;
            $display("FAIL reset_mid byte1 got %b %h want 1 %h", m_wr, m_data, data[15:8]);
        end
        reset = 1'b0;
        for (int j = 1; j <= 22; j++) begin
            @(negedge clock);
            checks++;
            if ({m_wr, m_busy, m_done} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid idle j=%0d got %b want 000", j, {m_wr, m_busy, m_done});
            end
            if (j == 2) reset = 1'b1;
        end
        run_frame("after_reset", rand_frame(), 1000, 0, 0);
        drive(1'b0, '0, 1'b0);
        @(negedge clock);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_frame("random", rand_frame(), $urandom_range(1, 12), $urandom_range(0, 6),
                      $urandom_range(1, 12));
        drive(1'b0, '0, 1'b0);
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_order();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
